// File: rtl/led_fader.sv
// ============================================================================
// Module   : led_fader
// Brief    : Per-LED linear PWM fader with shared step/PWM counters and bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_fader #(
    parameter int LED       = 4,
    parameter int PWM_W     = 8,
    parameter int FADE_STEP = 1000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LED-1:0] led_in,
    input  logic           bypass,
    output logic [LED-1:0] led_out,
    output logic           busy
);

    localparam int               c_sc_w      = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam logic [PWM_W-1:0] c_max       = '1;
    localparam logic [c_sc_w-1:0] c_last_step = c_sc_w'(FADE_STEP - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t              state_q  [LED];
    state_t              state_d  [LED];
    logic [PWM_W-1:0]    bright_q [LED];
    logic [PWM_W-1:0]    bright_d [LED];
    logic [c_sc_w-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [LED-1:0]      led_out_q, led_out_d;
    logic                busy_q, busy_d;
    logic                w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            led_out_q  <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < LED; i++) begin
                state_q[i]  <= ST_OFF;
                bright_q[i] <= '0;
            end
        end else begin
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_out_q  <= led_out_d;
            busy_q     <= busy_d;
            for (int i = 0; i < LED; i++) begin
                state_q[i]  <= state_d[i];
                bright_q[i] <= bright_d[i];
            end
        end
    end

    always_comb begin
        w_tick     = (step_cnt_q == c_last_step);
        step_cnt_d = w_tick ? '0 : step_cnt_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
    end

    // A direction change always wins over a tick; the guards on MAX/0 keep a
    // reversal at the rails from wrapping brightness.
    always_comb begin
        for (int i = 0; i < LED; i++) begin
            state_d[i]  = state_q[i];
            bright_d[i] = bright_q[i];
            if (bypass) begin
                state_d[i]  = led_in[i] ? ST_ON : ST_OFF;
                bright_d[i] = led_in[i] ? c_max : '0;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        if (led_in[i]) state_d[i] = ST_UP;
                    end
                    ST_UP: begin
                        if (!led_in[i]) begin
                            state_d[i] = ST_DOWN;
                        end else if (w_tick) begin
                            if (bright_q[i] != c_max) bright_d[i] = bright_q[i] + 1'b1;
                            if (bright_q[i] >= c_max - 1'b1) state_d[i] = ST_ON;
                        end
                    end
                    ST_ON: begin
                        if (!led_in[i]) state_d[i] = ST_DOWN;
                    end
                    ST_DOWN: begin
                        if (led_in[i]) begin
                            state_d[i] = ST_UP;
                        end else if (w_tick) begin
                            if (bright_q[i] != '0) bright_d[i] = bright_q[i] - 1'b1;
                            if (bright_q[i] <= {{(PWM_W-1){1'b0}}, 1'b1}) state_d[i] = ST_OFF;
                        end
                    end
                    default: state_d[i] = ST_OFF;
                endcase
            end
        end
    end

    always_comb begin
        led_out_d = '0;
        busy_d    = 1'b0;
        for (int i = 0; i < LED; i++) begin
            led_out_d[i] = (bright_q[i] == c_max) || (pwm_cnt_q < bright_q[i]);
            if (state_q[i] == ST_UP || state_q[i] == ST_DOWN) busy_d = 1'b1;
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_led_fader.sv
// ============================================================================
// Module   : tb_led_fader
// Brief    : Self-checking bench for led_fader against a cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_fader;

    localparam int c_led  = 4;
    localparam int c_pw   = 4;
    localparam int c_fs   = 4;
    localparam int c_max  = (1 << c_pw) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [c_led-1:0] led_in;
    logic             bypass;
    logic [c_led-1:0] led_out;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: a LED is a brightness level plus a ramp direction (+1/-1/0).
    int m_bright [c_led];
    int m_dir    [c_led];
    int m_step;
    int m_pwm;

    led_fader #(.LED(c_led), .PWM_W(c_pw), .FADE_STEP(c_fs)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .bypass  (bypass),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_step = 0;
        m_pwm  = 0;
        for (int i = 0; i < c_led; i++) begin
            m_bright[i] = 0;
            m_dir[i]    = 0;
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        logic [c_led-1:0] exp_out;
        logic             exp_busy;
        bit               tick;
        @(posedge clk);
        exp_out  = '0;
        exp_busy = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < c_led; i++) begin
                exp_out[i] = (m_bright[i] == c_max) || (m_pwm < m_bright[i]);
                if (m_dir[i] != 0) exp_busy = 1'b1;
            end
            tick   = (m_step == c_fs - 1);
            m_step = (m_step + 1) % c_fs;
            m_pwm  = (m_pwm + 1) % (c_max + 1);
            for (int i = 0; i < c_led; i++) begin
                if (bypass) begin
                    m_bright[i] = led_in[i] ? c_max : 0;
                    m_dir[i]    = 0;
                end else if (m_dir[i] == 0) begin
                    if (led_in[i] && m_bright[i] == 0)      m_dir[i] = 1;
                    if (!led_in[i] && m_bright[i] == c_max) m_dir[i] = -1;
                end else if ((m_dir[i] > 0) != led_in[i]) begin
                    m_dir[i] = -m_dir[i];
                end else if (tick) begin
                    m_bright[i] = m_bright[i] + m_dir[i];
                    if (m_bright[i] > c_max) m_bright[i] = c_max;
                    if (m_bright[i] < 0)     m_bright[i] = 0;
                    if (m_bright[i] == 0 || m_bright[i] == c_max) m_dir[i] = 0;
                end
            end
        end
        #1;
        check("led_out", 32'(led_out), 32'(exp_out));
        check("busy",    32'(busy),    32'(exp_busy));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int hi;
        int guard;
        rst    = 1'b1;
        led_in = 4'hF;
        bypass = 1'b0;
        model_reset();

        // Reset held with all LEDs requested
        run(2);
        rst    = 1'b0;
        led_in = 4'h0;
        run(3);

        // Fade up LED 0 all the way to ON
        led_in = 4'b0001;
        run(2);
        check("busy_rise", 32'(busy), 32'd1);
        run(15 * c_fs + c_fs + 4);
        check("led0_on", 32'(led_out[0]), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        run(16);

        // Ramp LED 0 down to 5, then freeze it by reversing every cycle
        led_in = 4'b0000;
        guard  = 0;
        while (m_bright[0] != 5 && guard < 200) begin
            cycle();
            guard++;
        end
        check("reach5_timeout", 32'(guard < 200), 32'd1);
        for (int k = 0; k < 4; k++) begin
            led_in[0] = ~led_in[0];
            cycle();
        end
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            led_in[0] = ~led_in[0];
            cycle();
            if (led_out[0]) hi++;
        end
        check("duty5", 32'(hi), 32'd5);
        led_in = 4'b0000;
        run(40);

        // Mid-ramp reversal on LED 1 at brightness 7
        led_in = 4'b0010;
        guard  = 0;
        while (m_bright[1] != 7 && guard < 200) begin
            cycle();
            guard++;
        end
        check("reach7_timeout", 32'(guard < 200), 32'd1);
        led_in = 4'b0000;
        run(8 * c_fs + 6);
        check("led1_off", 32'(led_out[1]), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);

        // Bypass during ramps on LEDs 2 and 3
        led_in = 4'b1100;
        run(10);
        bypass = 1'b1;
        led_in = 4'b0100;
        run(2);
        check("bypass_out", 32'(led_out), 32'h4);
        run(2);
        bypass = 1'b0;
        led_in = 4'b0000;
        run(2);
        check("bypass_fade_busy", 32'(busy), 32'd1);
        run(16 * c_fs + 4);

        // Reset while all LEDs ramp
        led_in = 4'hF;
        run(20);
        rst = 1'b1;
        run(1);
        check("rst_out", 32'(led_out), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        run(10);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) led_in = 4'($urandom);
            bypass = ($urandom_range(31) == 0);
            rst    = ($urandom_range(127) == 0);
            cycle();
        end
        rst    = 1'b0;
        bypass = 1'b0;
        run(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_fader.md
# led_fader

Downstream stage for the blinking LED driver. It takes the per-LED on/off pattern and drives the physical LED pins with PWM, fading each LED up or down linearly instead of switching it hard. Each LED has its own fade state machine and brightness register. One PWM counter and one fade-step counter are shared by all LEDs. There is a bypass mode for hard switching.

## Interface
- LED, 4: number of LEDs; must be ≥ 1.
- PWM_W, 8: brightness and PWM counter width; MAX = 2^PWM_W − 1.
- FADE_STEP, 1000: clock cycles per brightness step; must be ≥ 1.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- led_in  in  LED  target pattern, synchronous to clk; bit i = 1 requests LED i on.
- bypass  in  1  1 = hard switching, no fading.
- led_out  out  LED  PWM drive to the LED pins; registered.
- busy  out  1  1 while any LED is in UP or DOWN; registered.

## Operation
- **Reset:** every LED goes to OFF with bright = 0. pwm_cnt = 0, step_cnt = 0, led_out = 0, busy = 0.
- **Step counter:**
  - step_cnt counts 0..FADE_STEP−1 and wraps to 0.
  - tick = 1 in the cycle where step_cnt == FADE_STEP−1.
  - FADE_STEP = 1 gives tick = 1 every cycle.
- **PWM counter:** pwm_cnt is free-running, PWM_W bits wide, and wraps MAX → 0. The PWM period is 2^PWM_W cycles.
- **Per-LED FSM (states OFF, UP, ON, DOWN).** Transitions are evaluated every cycle:
  - OFF: led_in = 1 → UP.
  - UP:
    - led_in = 0 → DOWN, bright held. Direction change wins over tick: no increment in that cycle.
    - Otherwise, on tick, bright += 1.
    - When bright goes MAX−1 → MAX, the state becomes ON on the same edge.
  - ON: led_in = 0 → DOWN.
  - DOWN:
    - led_in = 1 → UP, bright held, no decrement in that cycle.
    - Otherwise, on tick, bright −= 1.
    - When bright goes 1 → 0, the state becomes OFF on the same edge.
  - bright never wraps; it saturates at 0 and MAX by construction.
- **Bypass = 1:**
  - Each LED goes directly to ON with bright = MAX if led_in = 1, else to OFF with bright = 0. Bypass overrides any in-progress ramp.
  - Clearing bypass resumes normal FSM behaviour from that ON/OFF state; no glitch.
- **Output:**
  - led_out[i] <= (bright[i] == MAX) | (pwm_cnt < bright[i]).
  - bright = 0 gives a constant 0; bright = MAX gives a constant 1.
  - Any other bright = B gives exactly B high cycles per PWM period.
- **busy:** busy <= OR over all LEDs of (state == UP or state == DOWN).
- LEDs are fully independent. Simultaneous changes on several LEDs are all handled in the same cycle.

## Timing
- A led_in edge at cycle t changes the state at edge t+1. busy rises at t+2.
- A bright change at edge t shows up in led_out at edge t+1 (one register stage).
- Full ramp from 0 to MAX: the LED enters UP at edge t+1, then needs MAX ticks. Duration ≈ MAX·FADE_STEP cycles. The first increment falls on the first tick after entry, so the phase depends on step_cnt.
- Bypass takes effect at the edge after assertion. led_out follows one cycle later.
- rst asserted mid-ramp: at the next edge all state returns to reset values, including counter phase. led_out = 0 from the edge after rst is sampled.
- Outputs are glitch-free; all of them are flop outputs.

## Test plan
All scenarios use PWM_W = 4 (MAX = 15), FADE_STEP = 4, LED = 4 unless noted.
- **Reset:** drive rst high for 2 cycles with led_in = 4'hF. Expect led_out = 0 and busy = 0 during and immediately after. After release, bright stays 0 until the first tick.
- **Fade up:** after reset, set led_in = 4'b0001 and hold.
  - Expect busy = 1 two cycles later.
  - Expect bright[0] to increment once every 4 cycles and reach 15 within 15·4 + 4 cycles.
  - Expect state ON, busy = 0, and led_out[0] constant 1.
- **Duty check:** freeze bright[0] = 5, either with a long FADE_STEP or by dropping led_in at the right moment. Expect exactly 5 high cycles per 16-cycle period on led_out[0].
- **Mid-ramp reversal:** led_in[1] = 1 until bright[1] = 7, then 0.
  - If the change coincides with a tick, expect no increment in that cycle.
  - Expect bright[1] to decrement from 7 and reach 0, state OFF, busy = 0.
- **Bypass:** during ramps on LEDs 2 and 3, assert bypass with led_in = 4'b0100.
  - Expect bright[2] = 15 and bright[3] = 0 next cycle, with led_out = 4'b0100 the cycle after.
  - Deassert bypass and set led_in = 0. Expect LED 2 to fade down normally.
- **Reset mid-operation:** assert rst while all 4 LEDs are ramping. Expect all brightness values = 0, led_out = 0 and busy = 0 after the next edge.
